mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of one shared memory-system port: Addr/DataIn/Rd/Wr in, DataOut/Done/Stall/CacheHit out.
- Port I is instruction fetch (read-only). Port D is data (read/write).
- Grants one requester at a time, holds the memory request stable until Done, and returns data and Done to the winner.
- Sits between the fetch/memory pipeline stages and the memory system. Also flags misaligned and timed-out accesses.

Parameters:
- TIMEOUT, 64, max cycles in BUSY without mem_done before abort (>=2).
- CNT_W, 7, width of the timeout counter (must hold TIMEOUT).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- i_rd  in  1  instruction read request
- i_addr  in  16  instruction address
- i_done  out  1  instruction access complete (1-cycle pulse)
- i_data  out  16  instruction read data, valid when i_done
- i_stall  out  1  i request pending, not yet done
- d_rd  in  1  data read request
- d_wr  in  1  data write request
- d_addr  in  16  data address
- d_wdata  in  16  data write data
- d_done  out  1  data access complete (1-cycle pulse)
- d_rdata  out  16  data read data, valid when d_done
- d_stall  out  1  d request pending, not yet done
- err  out  1  1-cycle pulse with a done: misaligned, rd&wr both set, or timeout
- mem_addr  out  16  to memory Addr
- mem_wdata  out  16  to memory DataIn
- mem_rd  out  1  to memory Rd
- mem_wr  out  1  to memory Wr
- mem_rdata  in  16  from memory DataOut
- mem_done  in  1  from memory Done
- mem_stall  in  1  from memory Stall (informational; only mem_done ends an access)
- hit  out  1  memory CacheHit qualified by mem_done, passed to the winner's cycle

Behaviour:
- Reset (sync, rst high at posedge): state IDLE; mem_rd, mem_wr, mem_addr, mem_wdata = 0; all done, err, stall outputs = 0; counter = 0; rr pointer = I. Reset mid-access abandons the access with no done.
- States:
  - IDLE: pending requests are sampled.
  - BUSY: memory is being driven.
  - RESP: one-cycle error response, no memory access.
- Arbitration in IDLE: D beats I (fixed priority). The grant is registered; mem_addr/mem_wdata/mem_rd/mem_wr are latched from the winner's inputs at that edge.
  - Arbitration latency: request seen in cycle N, mem_rd/mem_wr high from cycle N+1.
- Error requests go IDLE->RESP instead of BUSY, and never touch memory:
  - address bit 0 set (misaligned), or
  - d_rd & d_wr both set.
  - RESP: done+err for the winner for exactly one cycle, then IDLE.
- BUSY: mem outputs held constant. Counter increments each cycle.
  - mem_done=1: winner's done=1 and its data = mem_rdata (combinational pass-through, same cycle); hit = mem CacheHit. Next state IDLE; mem_rd/mem_wr deassert at that edge.
  - Counter reaches TIMEOUT-1 without mem_done: winner's done=1, err=1, data=0; drop mem_rd/mem_wr; return to IDLE.
- Stall: x_stall = (x request asserted) & ~x_done. The loser stalls throughout.
- Requesters hold address/data/request stable until done. A request still asserted in the cycle after done is a new request.
- Min access time is 2 cycles (arbitrate + 1 memory cycle). The back-to-back gap is one IDLE cycle.
- Non-winner done/data outputs are 0. i_done and d_done are never high together.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration. A 1-bit pointer records the last winner. On simultaneous requests in IDLE, the port not granted last wins. The pointer updates on every grant, including error grants.
- Undefined: fixed D-over-I priority; no pointer register.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_BUSY=2'd1, ST_RESP=2'd2;
  - grant encoding GNT_I=1'b0, GNT_D=1'b1;
  - the default TIMEOUT.
- One natural sub-module, mem_arb_timer: loadable counter with clear/enable and a terminal-count flag.

Test Plan:
- i_rd=1, i_addr=16'h0010, memory done after 1 cycle with 16'hABCD -> mem_rd high cycle N+1; i_done=1 and i_data=16'hABCD in cycle N+1; err=0.
- d_wr=1, d_addr=16'h0200, d_wdata=16'h1234, simultaneous i_rd -> D granted first: mem_wr=1, mem_wdata=16'h1234; d_done; one IDLE cycle; then I granted. i_stall=1 until its done.
- Simultaneous requests on two consecutive transactions with MEM_ARB_RR_EN defined -> grants alternate D, I, D. Undefined -> D, D.
- d_rd=1, d_addr=16'h0201 -> RESP: d_done=1, err=1 in cycle N+1; mem_rd/mem_wr never asserted.
- mem_done held 0, TIMEOUT=8 -> d_done=1, err=1, d_rdata=0 exactly 8 cycles after grant; mem_rd drops the following cycle.
- rst asserted during BUSY -> next cycle all outputs 0, state IDLE; the pending requester receives no done.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/grant encodings and default sizing for the
// memory arbiter and its timeout timer.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

    localparam int unsigned TIMEOUT_DEFAULT = 64;
    localparam int unsigned CNT_W_DEFAULT   = 7;

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: loadable up-counter with clear/enable and a terminal-count
// flag raised when the count equals TIMEOUT-1.
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear beats load beats increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) arbiter and sequencer in
// front of a single memory port. Misaligned or rd&wr requests get a one-cycle
// error response without touching memory; stalled accesses abort on timeout.
// Optional: define MEM_ARB_RR_EN for round-robin arbitration on simultaneous
// requests; otherwise D has fixed priority over I.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rd,
    input  logic [15:0] i_addr,
    output logic        i_done,
    output logic [15:0] i_data,
    output logic        i_stall,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_done,
    output logic [15:0] d_rdata,
    output logic        d_stall,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    input  logic        mem_stall,
    input  logic        mem_hit,
    output logic        hit
);

    state_e      state_q, state_d;
    gnt_e        gnt_q, gnt_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;

    logic        i_req, d_req;
    gnt_e        win;
    logic        win_bad, win_rd, win_wr;
    logic [15:0] win_addr, win_wdata;

    logic        tmr_clr, tmr_en, tmr_tc;
    logic [CNT_W-1:0] timer_cnt_unused;
    logic        mem_stall_unused;

    logic        rsp_done, rsp_err, rsp_hit;
    logic [15:0] rsp_data;

    assign i_req            = i_rd;
    assign d_req            = d_rd | d_wr;
    assign mem_stall_unused = mem_stall;

`ifdef MEM_ARB_RR_EN
    gnt_e last_q, last_d;

    // Last-winner pointer follows every grant, error grants included.
    always_comb begin
        last_d = last_q;
        if (state_q == ST_IDLE && (i_req || d_req)) begin
            last_d = win;
        end
    end

    // Last-winner register.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= GNT_I;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Pick the winner and form the request it would launch.
    always_comb begin
        win = GNT_I;
`ifdef MEM_ARB_RR_EN
        if (d_req && i_req) begin
            if (last_q == GNT_D) begin
                win = GNT_I;
            end else begin
                win = GNT_D;
            end
        end else if (d_req) begin
            win = GNT_D;
        end
`else
        if (d_req) begin
            win = GNT_D;
        end
`endif
        if (win == GNT_D) begin
            win_addr  = d_addr;
            win_wdata = d_wdata;
            win_rd    = d_rd;
            win_wr    = d_wr;
            win_bad   = d_addr[0] || (d_rd && d_wr);
        end else begin
            win_addr  = i_addr;
            win_wdata = '0;
            win_rd    = 1'b1;
            win_wr    = 1'b0;
            win_bad   = i_addr[0];
        end
    end

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .load     (1'b0),
        .load_val ('0),
        .cnt      (timer_cnt_unused),
        .tc       (tmr_tc)
    );

    // Next-state, memory request and response generation.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
        rsp_done    = 1'b0;
        rsp_err     = 1'b0;
        rsp_hit     = 1'b0;
        rsp_data    = '0;
        case (state_q)
            ST_IDLE: begin
                tmr_clr = 1'b1;
                if (i_req || d_req) begin
                    gnt_d = win;
                    if (win_bad) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d     = ST_BUSY;
                        mem_addr_d  = win_addr;
                        mem_wdata_d = win_wdata;
                        mem_rd_d    = win_rd;
                        mem_wr_d    = win_wr;
                    end
                end
            end
            ST_BUSY: begin
                tmr_en = 1'b1;
                if (mem_done) begin
                    rsp_done = 1'b1;
                    rsp_data = mem_rdata;
                    rsp_hit  = mem_hit;
                end else if (tmr_tc) begin
                    rsp_done = 1'b1;
                    rsp_err  = 1'b1;
                end
                if (rsp_done) begin
                    state_d  = ST_IDLE;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                end
            end
            ST_RESP: begin
                rsp_done = 1'b1;
                rsp_err  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Route the response to the granted port; the other port sees zeros.
    always_comb begin
        i_done  = rsp_done && (gnt_q == GNT_I);
        d_done  = rsp_done && (gnt_q == GNT_D);
        i_data  = i_done ? rsp_data : '0;
        d_rdata = d_done ? rsp_data : '0;
        err     = rsp_err;
        hit     = rsp_hit;
        i_stall = i_req && !i_done && !rst;
        d_stall = d_req && !d_done && !rst;
    end

    // State, grant and memory request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_I;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;

endmodule
